gray_sync_decoder: RTL

GRAY_SYNC_DECODER -- requirements
Module: gray_sync_decoder

---
 rtl/gray_sync_decoder.sv | 122 ++++++++++++
 1 files changed

// File: rtl/gray_sync_decoder.sv
// Gray-code pointer synchronizer and decoder.
// Brings a Gray-coded count from a foreign clock domain into aclk through a
// flop chain. It then decodes the count to binary and reports how far the
// count moved since the last sample.
// Optional feature: define GRAY_SYNC_DECODER_ERR_CHECK_EN to enable the sticky
// multi-bit Gray transition detector; otherwise err_multi_bit is tied to 0.
module gray_sync_decoder #(
    parameter int DWIDTH      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic [DWIDTH-1:0] gray_in,
    output logic [DWIDTH-1:0] gray_out,
    output logic [DWIDTH-1:0] bin_out,
    output logic              bin_valid,
    output logic              advance,
    output logic [DWIDTH-1:0] delta,
    output logic              err_multi_bit
);

    localparam int FW = $clog2(SYNC_STAGES + 2);
    // The fill count reaches SYNC_STAGES one edge before the first real
    // sample lands in gray_out/bin_out.
    localparam logic [FW-1:0] FILL_LAST = FW'(SYNC_STAGES);
    localparam logic [FW-1:0] FILL_MAX  = FW'(SYNC_STAGES + 1);

    logic [DWIDTH-1:0] r_sync [SYNC_STAGES];
    logic [DWIDTH-1:0] r_gray;
    logic [DWIDTH-1:0] r_bin;
    logic [DWIDTH-1:0] r_delta;
    logic              r_advance;
    logic              r_valid;
    logic [FW-1:0]     r_fill;

    logic [DWIDTH-1:0] w_gray_last;
    logic [DWIDTH-1:0] w_bin_next;
    logic              w_changed;

    // Bit i of the binary value is the XOR of all Gray bits at i and above.
    function automatic logic [DWIDTH-1:0] gray2bin(input logic [DWIDTH-1:0] g);
        logic [DWIDTH-1:0] b;
        b = '0;
        for (int i = 0; i < DWIDTH; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    assign w_gray_last = r_sync[SYNC_STAGES-1];
    assign w_bin_next  = gray2bin(w_gray_last);
    assign w_changed   = (w_bin_next != r_bin);

    // Synchronizer chain. The first flop samples gray_in directly, with no logic in front of it.
    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // Output register stage: decode, fill tracking, and step reporting.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_gray    <= '0;
            r_bin     <= '0;
            r_delta   <= '0;
            r_advance <= 1'b0;
            r_valid   <= 1'b0;
            r_fill    <= '0;
        end else begin
            r_gray <= w_gray_last;
            r_bin  <= w_bin_next;
            if (r_fill != FILL_MAX) begin
                r_fill <= r_fill + 1'b1;
            end
            if (r_fill == FILL_LAST) begin
                r_valid <= 1'b1;
            end
            // Steps are reported only once bin_valid was already high before
            // the edge. This keeps the reset-to-first-sample load silent.
            r_advance <= r_valid && w_changed;
            r_delta   <= (r_valid && w_changed) ? (w_bin_next - r_bin) : '0;
        end
    end

`ifdef GRAY_SYNC_DECODER_ERR_CHECK_EN
    logic [DWIDTH-1:0] w_gray_diff;
    logic              w_multi_bit;
    logic              r_err;

    // More than one bit set means clearing the lowest set bit leaves something behind.
    assign w_gray_diff = w_gray_last ^ r_gray;
    assign w_multi_bit = |(w_gray_diff & (w_gray_diff - 1'b1));

    // Sticky error flag for an illegal Gray transition.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_err <= 1'b0;
        end else if (r_valid && w_multi_bit) begin
            r_err <= 1'b1;
        end
    end

    assign err_multi_bit = r_err;
`else
    assign err_multi_bit = 1'b0;
`endif

    assign gray_out  = r_gray;
    assign bin_out   = r_bin;
    assign bin_valid = r_valid;
    assign advance   = r_advance;
    assign delta     = r_delta;

endmodule
